// File: rtl/tron_pkg.sv
// Shared definitions for the Tron core: condition codes, status-flag bit positions
// and the fetch FSM state encoding.
package tron_pkg;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_HI = 4'h4;
  localparam logic [3:0] CC_LS = 4'h5;
  localparam logic [3:0] CC_GT = 4'h6;
  localparam logic [3:0] CC_LE = 4'h7;
  localparam logic [3:0] CC_FS = 4'h8;
  localparam logic [3:0] CC_FC = 4'h9;
  localparam logic [3:0] CC_LO = 4'hA;
  localparam logic [3:0] CC_HS = 4'hB;
  localparam logic [3:0] CC_LT = 4'hC;
  localparam logic [3:0] CC_GE = 4'hD;
  localparam logic [3:0] CC_UC = 4'hE;
  localparam logic [3:0] CC_AL = 4'hF;

  // Status flags are packed as {N,Z,F,L,C}
  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    S_ISSUE   = 2'd0,
    S_CAPTURE = 2'd1,
    S_READY   = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: flag_op + status flags -> cond_taken.
// Shared by the fetch stage and any later stage that needs condition tests.
module cond_eval
  import tron_pkg::*;
(
  input  logic [3:0] flag_op,
  input  logic [4:0] flags,
  output logic       cond_taken
);

  logic n, z, f, l, c;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign f = flags[FLAG_F];
  assign l = flags[FLAG_L];
  assign c = flags[FLAG_C];

  // CC_AL shares the unconditional result; the controller uses it for JAL
  always_comb begin
    cond_taken = 1'b1;
    case (flag_op)
      CC_EQ:   cond_taken = z;
      CC_NE:   cond_taken = !z;
      CC_CS:   cond_taken = c;
      CC_CC:   cond_taken = !c;
      CC_HI:   cond_taken = l;
      CC_LS:   cond_taken = !l;
      CC_GT:   cond_taken = n;
      CC_LE:   cond_taken = !n;
      CC_FS:   cond_taken = f;
      CC_FC:   cond_taken = !f;
      CC_LO:   cond_taken = !l && !z;
      CC_HS:   cond_taken = l || z;
      CC_LT:   cond_taken = !n && !z;
      CC_GE:   cond_taken = n || z;
      CC_UC:   cond_taken = 1'b1;
      default: cond_taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC and instruction fetch stage of the Tron multicycle core.
// Optional feature: define PC_PERF_COUNTERS_EN to add retired/taken counters.
module pc_fetch_unit
  import tron_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_add,
  input  logic             pc_jump,
  input  logic             pc_branch,
  input  logic [3:0]       flag_op,
  input  logic [4:0]       flags,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] displacement,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] instruction,
  output logic             instr_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] link_addr,
  output logic             cond_taken
`ifdef PC_PERF_COUNTERS_EN
  ,
  output logic [15:0]      retired_count,
  output logic [15:0]      taken_count
`endif
);

  fetch_state_t     state, state_next;
  logic             strobe;
  logic [WIDTH-1:0] pc_next;

  cond_eval u_cond_eval (
    .flag_op    (flag_op),
    .flags      (flags),
    .cond_taken (cond_taken)
  );

  assign strobe    = pc_add || pc_jump || pc_branch;
  assign link_addr = pc + WIDTH'(1);
  assign mem_addr  = pc;

  // Branch outranks jump outranks add; an untaken condition still steps the PC
  always_comb begin
    pc_next = link_addr;
    if (pc_branch) begin
      if (cond_taken) pc_next = pc + displacement;
    end else if (pc_jump) begin
      if (cond_taken) pc_next = jump_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (strobe) begin
      pc <= pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_ISSUE;
    end else begin
      state <= state_next;
    end
  end

  // Any strobe restarts the fetch, abandoning a read already in flight
  always_comb begin
    state_next = state;
    if (strobe) begin
      state_next = S_ISSUE;
    end else begin
      case (state)
        S_ISSUE:   state_next = S_CAPTURE;
        S_CAPTURE: state_next = S_READY;
        S_READY:   state_next = S_READY;
        default:   state_next = S_ISSUE;
      endcase
    end
  end

  always_comb begin
    instr_ready = (state == S_READY);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      instruction <= '0;
    end else if (state == S_CAPTURE && !strobe) begin
      instruction <= mem_rdata;
    end
  end

`ifdef PC_PERF_COUNTERS_EN
  // Both counters stick at all-ones rather than wrapping
  always_ff @(posedge clk) begin
    if (!reset) begin
      retired_count <= '0;
      taken_count   <= '0;
    end else begin
      if (strobe && retired_count != 16'hFFFF) begin
        retired_count <= retired_count + 16'd1;
      end
      if ((pc_branch || pc_jump) && cond_taken && taken_count != 16'hFFFF) begin
        taken_count <= taken_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized self-checking bench for pc_fetch_unit against a PC/fetch-age model.
// Define PC_PERF_COUNTERS_EN to also check the performance counters.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic        pc_add, pc_jump, pc_branch;
  logic [3:0]  flag_op;
  logic [4:0]  flags;
  logic [15:0] jump_target, displacement;
  logic [15:0] mem_addr, mem_rdata, instruction, pc, link_addr;
  logic        instr_ready, cond_taken;
`ifdef PC_PERF_COUNTERS_EN
  logic [15:0] retired_count, taken_count;
`endif

  logic [15:0] mem [0:65535];

  int          errorCount = 0;
  int          checkCount = 0;

  logic [15:0] mPc;
  logic [15:0] mInstr;
  int          mAge;
  int          mRetired;
  int          mTaken;
  bit          mValid = 1'b0;

  pc_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .pc_add       (pc_add),
    .pc_jump      (pc_jump),
    .pc_branch    (pc_branch),
    .flag_op      (flag_op),
    .flags        (flags),
    .jump_target  (jump_target),
    .displacement (displacement),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .instruction  (instruction),
    .instr_ready  (instr_ready),
    .pc           (pc),
    .link_addr    (link_addr),
    .cond_taken   (cond_taken)
`ifdef PC_PERF_COUNTERS_EN
    ,
    .retired_count(retired_count),
    .taken_count  (taken_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) mem_rdata <= mem[mem_addr];

  // Codes 0-9 test one flag, odd codes inverting; 10-13 test a pair; 14-15 always
  function automatic logic condModel(input logic [3:0] op, input logic [4:0] fl);
    logic n, z, f, l, c, base;
    {n, z, f, l, c} = fl;
    if (op >= 4'd14) return 1'b1;
    if (op < 4'd10) begin
      case (op >> 1)
        4'd0:    base = z;
        4'd1:    base = c;
        4'd2:    base = l;
        4'd3:    base = n;
        default: base = f;
      endcase
      return base ^ op[0];
    end
    base = (op < 4'd12) ? (l | z) : (n | z);
    return op[0] ? base : !base;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, checks the combinational outputs, steps the model
  // across the clock edge and checks the registered outputs.
  task automatic applyStimulus(input logic rstN, input logic add, input logic jump,
                               input logic branch, input logic [3:0] op,
                               input logic [4:0] fl, input logic [15:0] tgt,
                               input logic [15:0] disp);
    logic taken;
    reset = rstN; pc_add = add; pc_jump = jump; pc_branch = branch;
    flag_op = op; flags = fl; jump_target = tgt; displacement = disp;
    #1;
    taken = condModel(op, fl);
    checkOutput("cond_taken", {15'd0, cond_taken}, {15'd0, taken});
    if (mValid) begin
      checkOutput("link_addr", link_addr, mPc + 16'd1);
      checkOutput("mem_addr", mem_addr, mPc);
    end
    @(posedge clk);
    if (!rstN) begin
      mPc = 16'h0000; mInstr = 16'h0000; mAge = 0;
      mRetired = 0; mTaken = 0; mValid = 1'b1;
    end else if (mValid) begin
      if (add || jump || branch) begin
        if (branch)    mPc = taken ? mPc + disp : mPc + 16'd1;
        else if (jump) mPc = taken ? tgt : mPc + 16'd1;
        else           mPc = mPc + 16'd1;
        mAge = 0;
        if (mRetired < 65535) mRetired++;
        if ((branch || jump) && taken && mTaken < 65535) mTaken++;
      end else begin
        if (mAge == 1) mInstr = mem[mPc];
        if (mAge < 2) mAge++;
      end
    end
    #1;
    if (mValid) begin
      checkOutput("pc", pc, mPc);
      checkOutput("instr_ready", {15'd0, instr_ready}, (mAge == 2) ? 16'd1 : 16'd0);
      checkOutput("instruction", instruction, mInstr);
`ifdef PC_PERF_COUNTERS_EN
      checkOutput("retired_count", retired_count, 16'(mRetired));
      checkOutput("taken_count", taken_count, 16'(mTaken));
`endif
    end
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 5'h00, 16'h0000, 16'h0000);
  endtask

  task automatic jumpTo(input logic [15:0] target);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'hE, 5'h00, target, 16'h0000);
    idle();
    idle();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h5103;

    // Reset and first fetch
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 5'h00, 16'h0000, 16'h0000);
    checkOutput("reset_pc", pc, 16'h0000);
    checkOutput("reset_ready", {15'd0, instr_ready}, 16'd0);
    idle();
    checkOutput("fetch_wait", {15'd0, instr_ready}, 16'd0);
    idle();
    checkOutput("fetch_ready", {15'd0, instr_ready}, 16'd1);
    checkOutput("fetch_word", instruction, 16'h5103);

    // Backward branch from 5, taken and not taken on Z
    jumpTo(16'h0005);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 5'b01000, 16'h0000, 16'hFFFD);
    checkOutput("branch_taken", pc, 16'h0002);
    checkOutput("branch_drop_ready", {15'd0, instr_ready}, 16'd0);
    jumpTo(16'h0005);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 5'b00000, 16'h0000, 16'hFFFD);
    checkOutput("branch_not_taken", pc, 16'h0006);

    // JAL pair: add then always-jump on the next cycle
    jumpTo(16'h0010);
    checkOutput("jal_link", link_addr, 16'h0011);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 5'h00, 16'h0000, 16'h0000);
    checkOutput("jal_add", pc, 16'h0011);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 5'h00, 16'h0040, 16'h0000);
    checkOutput("jal_jump", pc, 16'h0040);
    idle();
    idle();
    checkOutput("jal_ready", {15'd0, instr_ready}, 16'd1);

    // PC wrap
    jumpTo(16'hFFFF);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 5'h00, 16'h0000, 16'h0000);
    checkOutput("pc_wrap", pc, 16'h0000);

    // Reset landing on the capture cycle
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 5'h00, 16'h0000, 16'h0000);
    idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 5'h00, 16'h0000, 16'h0000);
    checkOutput("midreset_instr", instruction, 16'h0000);
    checkOutput("midreset_pc", pc, 16'h0000);
    idle();
    idle();
    checkOutput("midreset_refetch", instruction, 16'h5103);

`ifdef PC_PERF_COUNTERS_EN
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 5'h00, 16'h0000, 16'h0000);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 5'h00, 16'h0000, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'hE, 5'h00, 16'h0000, 16'h0004);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 5'h00, 16'h0100, 16'h0000);
    checkOutput("perf_retired", retired_count, 16'd5);
    checkOutput("perf_taken", taken_count, 16'd1);
`endif

    // Random traffic, including overlapping strobes to exercise priority
    for (int i = 0; i < 600; i++) begin
      int r;
      logic rstN, add, jump, branch;
      r      = int'($urandom_range(0, 99));
      rstN   = (r >= 2);
      add    = (r >= 2) && (r < 20);
      jump   = (r >= 12) && (r < 30);
      branch = (r >= 25) && (r < 40);
      applyStimulus(rstN, add, jump, branch, 4'($urandom), 5'($urandom),
                    16'($urandom), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
